// File: rtl/rs_pkg.sv
// Shared definitions for the DVB-T RS(204,188) encoder and decoder blocks.
// GF(256) with primitive polynomial 0x11D, alpha = 0x02, first root alpha^0.
package rs_pkg;

   localparam int unsigned GF_W    = 8;
   localparam logic [8:0]  GF_POLY = 9'h11D;

   localparam int unsigned RS_N    = 204;
   localparam int unsigned RS_K    = 188;
   localparam int unsigned RS_NPAR = 16;

   // g(x) = prod_{i=0..15} (x + alpha^i); G_COEF[j] is the x^j coefficient, x^16 is monic
   localparam logic [GF_W-1:0] G_COEF [0:RS_NPAR-1] = '{
      8'h3B, 8'h24, 8'h32, 8'h62, 8'hE5, 8'h29, 8'h41, 8'hA3,
      8'h08, 8'h1E, 8'hD1, 8'h44, 8'hBD, 8'h68, 8'h0D, 8'h3B
   };

   typedef enum logic {
      DATA   = 1'b0,
      PARITY = 1'b1
   } rs_state_e;

   // Multiply by alpha (x) modulo the field polynomial.
   function automatic logic [GF_W-1:0] gf_xtime(input logic [GF_W-1:0] a);
      return {a[GF_W-2:0], 1'b0} ^ (a[GF_W-1] ? GF_POLY[GF_W-1:0] : GF_W'(0));
   endfunction

endpackage

// File: rtl/gf256_mul_const.sv
// Multiply a GF(256) element by the constant C; folds to a pure XOR network.
module gf256_mul_const
   import rs_pkg::*;
#(
   parameter logic [GF_W-1:0] C = 8'h01
) (
   input  logic [GF_W-1:0] in,
   output logic [GF_W-1:0] out
);

   function automatic logic [GF_W-1:0] mul_c(input logic [GF_W-1:0] a);
      logic [GF_W-1:0] acc;
      logic [GF_W-1:0] p;
      acc = '0;
      p   = a;
      for (int k = 0; k < int'(GF_W); k++) begin
         if (C[k]) acc = acc ^ p;
         p = gf_xtime(p);
      end
      return acc;
   endfunction

   assign out = mul_c(in);

endmodule

// File: rtl/rs_encoder.sv
// Systematic RS(204,188) encoder: forwards 188 data bytes, then appends the
// 16-byte remainder of d(x)*x^16 mod g(x) held in a 16-stage LFSR.
module rs_encoder
   import rs_pkg::*;
(
   input  logic            Clk,
   input  logic            Reset,
   input  logic [GF_W-1:0] In_Data,
   input  logic            In_Valid,
   output logic            In_Ready,
   output logic [GF_W-1:0] Out_Data,
   output logic            Out_Valid,
   output logic            Out_Sop,
   output logic            Out_Eop,
   input  logic            Out_Ready
);

   localparam int unsigned CNT_W     = 8;
   localparam int unsigned DATA_LAST = RS_K - 1;
   localparam int unsigned PAR_LAST  = RS_N - RS_K - 1;

   rs_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [GF_W-1:0] r_q [RS_NPAR];
   logic [GF_W-1:0] r_d [RS_NPAR];
   logic [GF_W-1:0] gfb [RS_NPAR];
   logic [GF_W-1:0] fb;
   logic [GF_W-1:0] data_d;
   logic            valid_d, sop_d, eop_d;
   logic            adv, accept;

   assign adv      = !Out_Valid || Out_Ready;
   assign In_Ready = Reset && (state_q == DATA) && adv;
   assign accept   = In_Valid && In_Ready;

   // Feedback is forced to zero while draining parity so the LFSR just shifts.
   assign fb = (state_q == DATA) ? (In_Data ^ r_q[RS_NPAR-1]) : '0;

   for (genvar j = 0; j < int'(RS_NPAR); j++) begin : g_mul
      gf256_mul_const #(.C(G_COEF[j])) u_mul (
         .in  (fb),
         .out (gfb[j])
      );
   end

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         state_q   <= DATA;
         cnt_q     <= '0;
         for (int j = 0; j < int'(RS_NPAR); j++) r_q[j] <= '0;
         Out_Data  <= '0;
         Out_Valid <= 1'b0;
         Out_Sop   <= 1'b0;
         Out_Eop   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         for (int j = 0; j < int'(RS_NPAR); j++) r_q[j] <= r_d[j];
         Out_Data  <= data_d;
         Out_Valid <= valid_d;
         Out_Sop   <= sop_d;
         Out_Eop   <= eop_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      for (int j = 0; j < int'(RS_NPAR); j++) r_d[j] = r_q[j];
      data_d  = Out_Data;
      valid_d = Out_Valid;
      sop_d   = Out_Sop;
      eop_d   = Out_Eop;

      // One LFSR step per emitted byte; with fb = 0 this is a plain shift-up.
      if (accept || (state_q == PARITY && adv)) begin
         r_d[0] = gfb[0];
         for (int j = 1; j < int'(RS_NPAR); j++) r_d[j] = r_q[j-1] ^ gfb[j];
      end

      if (accept) begin
         data_d  = In_Data;
         valid_d = 1'b1;
         sop_d   = (cnt_q == '0);
         eop_d   = 1'b0;
         if (cnt_q == CNT_W'(DATA_LAST)) begin
            state_d = PARITY;
            cnt_d   = '0;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end else if (state_q == PARITY && adv) begin
         data_d  = r_q[RS_NPAR-1];
         valid_d = 1'b1;
         sop_d   = 1'b0;
         eop_d   = (cnt_q == CNT_W'(PAR_LAST));
         if (cnt_q == CNT_W'(PAR_LAST)) begin
            state_d = DATA;
            cnt_d   = '0;
            for (int j = 0; j < int'(RS_NPAR); j++) r_d[j] = '0;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end else if (adv) begin
         valid_d = 1'b0;
      end
   end

endmodule

// File: tb/tb_rs_encoder.sv
// Directed bench for rs_encoder: known parity vectors, an independent
// long-division model, syndrome checks, backpressure, reset and back-to-back.
module tb_rs_encoder;

   typedef logic [7:0] pkt_t [0:187];
   typedef logic [7:0] cw_t  [0:203];
   typedef struct packed { logic [7:0] d; logic sop; logic eop; } obyte_t;

   logic       Clk = 1'b0;
   logic       Reset;
   logic [7:0] In_Data;
   logic       In_Valid;
   logic       In_Ready;
   logic [7:0] Out_Data;
   logic       Out_Valid;
   logic       Out_Sop;
   logic       Out_Eop;
   logic       Out_Ready;

   int errors = 0;
   int checks = 0;
   bit rnd    = 1'b0;

   obyte_t      oq[$];
   int unsigned ocyc[$];
   int unsigned cyc     = 0;
   int          in_pkt  = 0;
   int          ir_viol = 0;
   int          b2b_hit = 0;

   logic [7:0] gen [0:16];

   rs_encoder dut (
      .Clk       (Clk),
      .Reset     (Reset),
      .In_Data   (In_Data),
      .In_Valid  (In_Valid),
      .In_Ready  (In_Ready),
      .Out_Data  (Out_Data),
      .Out_Valid (Out_Valid),
      .Out_Sop   (Out_Sop),
      .Out_Eop   (Out_Eop),
      .Out_Ready (Out_Ready)
   );

   always #5 Clk = ~Clk;

   // Handoff monitor, sampled mid-cycle while all handshake signals are stable.
   always @(negedge Clk) begin
      cyc <= cyc + 1;
      if (!Reset) begin
         in_pkt <= 0;
      end else begin
         if (in_pkt == 188 && In_Ready && !(Out_Valid && Out_Ready && Out_Eop))
            ir_viol <= ir_viol + 1;
         if (Out_Valid && Out_Ready) begin
            oq.push_back('{d: Out_Data, sop: Out_Sop, eop: Out_Eop});
            ocyc.push_back(cyc);
         end
         if (Out_Valid && Out_Ready && Out_Eop)
            in_pkt <= (In_Valid && In_Ready) ? 1 : 0;
         else if (In_Valid && In_Ready)
            in_pkt <= in_pkt + 1;
         if (In_Valid && In_Ready && Out_Valid && Out_Ready && Out_Eop)
            b2b_hit <= b2b_hit + 1;
      end
   end

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
      end
      return p;
   endfunction

   // Reference codeword by polynomial long division of d(x)*x^16 by g(x).
   function automatic cw_t encode(input pkt_t d);
      cw_t m;
      logic [7:0] c;
      for (int i = 0; i < 204; i++) m[i] = (i < 188) ? d[i] : 8'h00;
      for (int i = 0; i < 188; i++) begin
         c = m[i];
         for (int k = 1; k <= 16; k++) m[i+k] = m[i+k] ^ gmul(c, gen[16-k]);
      end
      for (int i = 0; i < 188; i++) m[i] = d[i];
      return m;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
      if (rnd) Out_Ready = 1'($urandom_range(0, 1));
   endtask

   task automatic send_byte(input logic [7:0] d);
      logic ok;
      In_Data  = d;
      In_Valid = 1'b1;
      for (int i = 0; i < 500; i++) begin
         @(negedge Clk);
         ok = In_Ready;
         step();
         if (ok) return;
      end
      chk("send_timeout", 32'd0, 32'd1);
   endtask

   task automatic send_pkt(input pkt_t p, input bit gaps);
      for (int i = 0; i < 188; i++) begin
         if (gaps && $urandom_range(0, 3) == 0) begin
            In_Valid = 1'b0;
            step();
         end
         send_byte(p[i]);
      end
   endtask

   task automatic drain(input int target);
      In_Valid = 1'b0;
      for (int i = 0; i < 3000 && oq.size() < target; i++) step();
      rnd       = 1'b0;
      Out_Ready = 1'b1;
      for (int i = 0; i < 4; i++) step();
      chk("drain_count", 32'(oq.size()), 32'(target));
   endtask

   task automatic cmp_cw(input string tag, input int base, input cw_t e);
      obyte_t o;
      for (int n = 0; n < 204; n++) begin
         o = (base + n < oq.size()) ? oq[base+n] : '0;
         chk($sformatf("%s_d%0d", tag, n), 32'(o.d), 32'(e[n]));
         chk($sformatf("%s_sop%0d", tag, n), 32'(o.sop), 32'(n == 0));
         chk($sformatf("%s_eop%0d", tag, n), 32'(o.eop), 32'(n == 203));
      end
   endtask

   // Evaluates the captured codeword at alpha^0..alpha^15; every root must vanish.
   task automatic chk_synd(input string tag, input int base);
      logic [7:0] root;
      logic [7:0] s;
      root = 8'h01;
      for (int i = 0; i < 16; i++) begin
         s = 8'h00;
         for (int n = 0; n < 204; n++)
            s = gmul(s, root) ^ ((base + n < oq.size()) ? oq[base+n].d : 8'h00);
         chk($sformatf("%s_S%0d", tag, i + 1), 32'(s), 32'd0);
         root = gmul(root, 8'h02);
      end
   endtask

   initial begin
      pkt_t       pz, p1, pa, pb, pc, pones;
      cw_t        ea, eb, ec, eones;
      logic [7:0] exp_par [0:15];
      logic [7:0] root;
      int         qb, iv0, bb0;

      exp_par = '{8'h3B, 8'h0D, 8'h68, 8'hBD, 8'h44, 8'hD1, 8'h1E, 8'h08,
                  8'hA3, 8'h41, 8'h29, 8'hE5, 8'h62, 8'h32, 8'h24, 8'h3B};

      for (int k = 0; k <= 16; k++) gen[k] = (k == 0) ? 8'h01 : 8'h00;
      root = 8'h01;
      for (int i = 0; i < 16; i++) begin
         for (int k = 16; k >= 1; k--) gen[k] = gen[k-1] ^ gmul(gen[k], root);
         gen[0] = gmul(gen[0], root);
         root   = gmul(root, 8'h02);
      end

      for (int i = 0; i < 188; i++) begin
         pz[i]    = 8'h00;
         p1[i]    = (i == 187) ? 8'h01 : 8'h00;
         pa[i]    = 8'($urandom);
         pb[i]    = 8'($urandom);
         pc[i]    = 8'($urandom);
         pones[i] = 8'h01;
      end
      ea    = encode(pa);
      eb    = encode(pb);
      ec    = encode(pc);
      eones = encode(pones);

      // Reset state
      Reset     = 1'b0;
      In_Valid  = 1'b0;
      In_Data   = 8'h00;
      Out_Ready = 1'b1;
      step(); step(); step();
      @(negedge Clk);
      chk("rst_valid", 32'(Out_Valid), 32'd0);
      chk("rst_data",  32'(Out_Data),  32'h00);
      chk("rst_sop",   32'(Out_Sop),   32'd0);
      chk("rst_eop",   32'(Out_Eop),   32'd0);
      chk("rst_ready", 32'(In_Ready),  32'd0);
      step();
      Reset = 1'b1;
      step();

      // All-zero packet at full rate
      qb = oq.size();
      send_pkt(pz, 1'b0);
      drain(qb + 204);
      for (int n = 0; n < 204; n++) begin
         chk($sformatf("zero_d%0d", n), 32'(oq[qb+n].d), 32'h00);
         chk($sformatf("zero_sop%0d", n), 32'(oq[qb+n].sop), 32'(n == 0));
         chk($sformatf("zero_eop%0d", n), 32'(oq[qb+n].eop), 32'(n == 203));
      end
      chk("zero_span", ocyc[qb+203] - ocyc[qb], 32'd203);

      // Single 0x01 at the last data byte: parity is g15..g0
      qb = oq.size();
      send_pkt(p1, 1'b0);
      drain(qb + 204);
      for (int n = 0; n < 16; n++)
         chk($sformatf("unit_par%0d", n), 32'(oq[qb+188+n].d), 32'(exp_par[n]));
      chk("unit_last_data", 32'(oq[qb+187].d), 32'h01);

      // Random packet at full rate
      qb = oq.size();
      send_pkt(pa, 1'b0);
      drain(qb + 204);
      cmp_cw("randA", qb, ea);
      chk_synd("randA", qb);

      // Same packet with random backpressure and input gaps
      qb  = oq.size();
      iv0 = ir_viol;
      rnd = 1'b1;
      send_pkt(pa, 1'b1);
      drain(qb + 204);
      cmp_cw("bp", qb, ea);
      chk("bp_inready_parity", 32'(ir_viol - iv0), 32'd0);

      // Reset at data byte 100, then a clean all-0x01 packet
      for (int i = 0; i < 100; i++) send_byte(pb[i]);
      In_Valid = 1'b0;
      Reset    = 1'b0;
      step();
      chk("mid_rst_valid", 32'(Out_Valid), 32'd0);
      chk("mid_rst_ready", 32'(In_Ready), 32'd0);
      Reset = 1'b1;
      qb    = oq.size();
      send_pkt(pones, 1'b0);
      drain(qb + 204);
      cmp_cw("ones", qb, eones);

      // Back-to-back codewords
      qb  = oq.size();
      iv0 = ir_viol;
      bb0 = b2b_hit;
      send_pkt(pb, 1'b0);
      send_pkt(pc, 1'b0);
      drain(qb + 408);
      cmp_cw("b2b1", qb, eb);
      cmp_cw("b2b2", qb + 204, ec);
      chk_synd("b2b2", qb + 204);
      chk("b2b_handoff", 32'(b2b_hit - bb0), 32'd1);
      chk("b2b_inready_parity", 32'(ir_viol - iv0), 32'd0);
      chk("b2b_span", ocyc[qb+407] - ocyc[qb], 32'd407);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/rs_encoder.md
# rs_encoder

Systematic Reed-Solomon RS(204,188, t=8) encoder over GF(2^8) for the DVB-T transmit chain. It is the transmit-side counterpart of the RS decoder (syndrome, sigma, z and Forney blocks). It accepts 188-byte MPEG-TS packets as a byte stream, passes the data bytes through unchanged, and appends 16 parity bytes. The parity bytes come from a 16-stage LFSR that divides by the code generator polynomial.

## Interface
- K, 188: data bytes per packet.
- NPAR, 16: parity bytes per packet (2t).
- Clk  in  1  clock; all logic on rising edge.
- Reset  in  1  reset, synchronous, active-low; clock Clk.
- In_Data  in  8  data byte, polynomial basis, bit 7 = MSB.
- In_Valid  in  1  In_Data valid.
- In_Ready  out  1  encoder accepts In_Data this cycle; combinational.
- Out_Data  out  8  encoded byte; registered.
- Out_Valid  out  1  Out_Data valid; registered.
- Out_Sop  out  1  first byte of the 204-byte codeword; qualified by Out_Valid.
- Out_Eop  out  1  last parity byte (byte 203); qualified by Out_Valid.
- Out_Ready  in  1  downstream accepts Out_Data.

## Operation
- Field: GF(256), primitive polynomial x^8+x^4+x^3+x^2+1 (0x11D), α = 0x02.
- Generator: g(x) = ∏_{i=0..15}(x+α^i) = x^16 + g15·x^15 + … + g0. Coefficients g0..g15 are package constants.
- Registers: r[0..15], 8 bits each, all zero at packet start.
- Per accepted data byte d:
  - fb = d ^ r[15]
  - r[j] ← r[j-1] ^ gj·fb for j = 1..15
  - r[0] ← g0·fb
  - Out_Data ← d
- Multiplication by a constant is pure XOR logic. No table ROMs and no $readmem.
- FSM:
  - DATA: counter 0..187 counts accepted bytes. The handshake on byte 187 moves to PARITY with counter = 0.
  - PARITY: on each output advance, Out_Data ← r[15], then r ← r shifted up by one with r[0] ← 0. Feedback is forced to zero. After the 16th parity byte: state = DATA, counter = 0, r = 0.
- Out_Sop = 1 on the byte launched with DATA counter = 0.
- Out_Eop = 1 on the byte launched with PARITY counter = 15.
- Output advance condition: adv = !Out_Valid || Out_Ready.
- In_Ready = Reset && (state == DATA) && adv.
- In_Valid while In_Ready = 0 is ignored; the upstream holds the byte.
- An accepted input (In_Valid && In_Ready) loads the output register.
- In PARITY, each adv loads the output register.
- If adv holds but nothing is loaded, Out_Valid ← 0.
- Reset mid-packet: the partial codeword is discarded. State = DATA, counter = 0, r = 0, and any output byte not yet taken is dropped.

## Timing
- Reset values: Out_Valid = 0, Out_Data = 0x00, Out_Sop = 0, Out_Eop = 0, In_Ready = 0 while Reset = 0, r = 0, state = DATA, counter = 0.
- Latency: an input accepted at edge n appears on Out_Data after edge n, i.e. 1 cycle.
- Throughput with Out_Ready held high: 204 output cycles per 188 input bytes. In_Ready is low for exactly 16 cycles per packet, starting the cycle after byte 187 is accepted.
- The first parity byte follows data byte 187 with no bubble.
- The next packet's byte 0 is accepted in the cycle Out_Eop is handed off (Out_Valid && Out_Ready && Out_Eop). In that cycle In_Ready = 1, so codewords can be back-to-back.
- Out_Ready low: Out_Data, Out_Valid, Out_Sop, Out_Eop, r and counter all hold, and In_Ready = 0.
- An input gap (In_Valid low in DATA): registers hold, and Out_Valid drops after the pending byte is taken.

## Structure
- Package rs_pkg holds:
  - GF_POLY = 9'h11D
  - RS_N = 204, RS_K = 188, RS_NPAR = 16
  - localparam array G_COEF[0:15]
  - state enum {DATA, PARITY}
- Sub-module gf256_mul_const:
  - Parameter C: 8-bit constant.
  - Ports: in [7:0], out [7:0].
  - Combinational XOR network, instantiated 16 times.
- The decoder blocks share rs_pkg.

## Test plan
- All-zero packet, Out_Ready = 1 -> 188×0x00 then 16×0x00. Out_Sop on byte 0, Out_Eop on byte 203, 204 consecutive Out_Valid cycles.
- Packet of 187×0x00 then 0x01 -> parity bytes in order g15, g14, …, g0. The remainder of x^16 mod g(x) equals g(x) − x^16.
- Random packets -> output matches the software RS(204,188) model. Every codeword has all 16 syndromes S1..S16 = 0 when fed through the existing syndrome block.
- Out_Ready toggled pseudo-randomly at 50% with In_Valid gaps -> byte stream identical to the Out_Ready = 1 run, no byte dropped or duplicated, and In_Ready never high in PARITY.
- Reset pulsed low for 1 cycle at data byte 100, then a fresh all-0x01 packet -> no stale parity. Output equals a clean encoding of that packet.
- Two packets back-to-back -> byte 0 of packet 2 is accepted in the Out_Eop handoff cycle of packet 1, and both parity sets are correct.
